memory_island_bank_arbiter: RTL
===============================

// Module: memory_island_bank_arbiter
// PURPOSE
//  Shares one SRAM bank of the memory island between NumNarrow narrow and NumWide wide requesters.
//  Narrow class has priority by default; a wait counter hands the bank to the wide class after
//  WidePriorityWait stalled cycles. Round-robin within each class. Routes each response back to
//  its requester after the fixed bank latency. Sits between the narrow/wide crossbars and a bank.
// PARAMETERS
//  NumNarrow        2    narrow requesters on this bank (>=1)
//  NumWide          2    wide requesters on this bank (>=1)
//  AddrWidth        10   bank word-address width
//  DataWidth        64   bank word width (both classes, already split/aligned upstream)
//  WidePriorityWait 1    stalled wide cycles before wide boost; 0 = narrow priority forever
//  BankLatency      1    cycles from bank_req_o to bank_rdata_i valid (>=1)
// PORTS
//  clk_i            in   1                      clock
//  rst_ni           in   1                      async reset, active low
//  narrow_req_i     in   NumNarrow              request valid per narrow port
//  narrow_gnt_o     out  NumNarrow              one-hot-or-zero grant, same cycle
//  narrow_addr_i    in   NumNarrow*AddrWidth    word address
//  narrow_we_i      in   NumNarrow              1 = write
//  narrow_wdata_i   in   NumNarrow*DataWidth    write data
//  narrow_strb_i    in   NumNarrow*DataWidth/8  byte strobes
//  narrow_rvalid_o  out  NumNarrow              response valid (reads and writes)
//  narrow_rdata_o   out  DataWidth              read data, shared, valid with rvalid
//  wide_*           --   as narrow_*, NumWide instead of NumNarrow
//  bank_req_o       out  1                      bank access this cycle
//  bank_we_o        out  1                      write enable
//  bank_addr_o      out  AddrWidth              bank address
//  bank_wdata_o     out  DataWidth              write data
//  bank_strb_o      out  DataWidth/8            byte enables
//  bank_rdata_i     in   DataWidth              read data, BankLatency cycles after req
// BEHAVIOUR
//  - Reset: pointers=0, wait_cnt=0, FSM=NARROW_PRIO, response pipe cleared -> all rvalid_o=0.
//    Gnt/bank outputs combinational from req; in-flight responses at reset are dropped.
//  - At most one grant per cycle across both classes; bank_req_o = |gnt. gnt independent of gnt.
//  - Request held stable until granted; no ready on response side (rvalid cannot stall).
//  - FSM NARROW_PRIO: any narrow req -> grant narrow; else grant wide if any.
//    wait_cnt++ each cycle wide req pending and no wide grant; wait_cnt=0 on any wide grant.
//    wait_cnt==WidePriorityWait-1 and wide stalled (WidePriorityWait>0) -> WIDE_BOOST next cycle.
//  - FSM WIDE_BOOST: any wide req -> grant wide, go NARROW_PRIO, wait_cnt=0; no wide req
//    (cannot occur with held reqs) -> behave as NARROW_PRIO, return to NARROW_PRIO.
//  - Round-robin per class: search from ptr; on grant ptr := granted_idx+1 mod N; else unchanged.
//  - Response pipe: BankLatency-deep shift register of {valid, class, idx(max width)} loaded on
//    grant; at tail valid -> rvalid of that port for exactly 1 cycle, rdata_o = bank_rdata_i.
//    Latency grant->rvalid = BankLatency cycles exactly; back-to-back grants -> back-to-back rvalid.
//  - wait_cnt width $clog2(WidePriorityWait+1); saturates, never wraps.
//  - Non-granted class rvalid=0; rdata_o driven to both classes (dont-care when rvalid=0).
// TESTING
//  1 Reset, narrow[0] read addr 0x10, BankLatency=2 -> gnt same cycle, narrow_rvalid_o[0]=1 at +2.
//  2 narrow[0],narrow[1] held every cycle, no wide -> grants alternate 0,1,0,1; rvalid follows.
//  3 WidePriorityWait=1, narrow[0] and wide[1] held -> pattern narrow,wide,narrow,wide.
//  4 WidePriorityWait=3, narrow+wide held -> narrow x3, wide x1, repeating; wait_cnt max 2.
//  5 WidePriorityWait=0, narrow held 20 cycles + wide -> wide never granted until narrow drops.
//  6 rst_ni low with 2 reads in flight -> no rvalid after reset; next request latency unchanged.

Source files
------------

// File: rtl/memory_island_bank_arbiter_if.sv
// Request/response bundle between the narrow/wide crossbars, the bank arbiter and one SRAM bank.
// Signal suffixes are from the arbiter's point of view.
interface memory_island_bank_arbiter_if #(
  parameter int unsigned NumNarrow = 2,
  parameter int unsigned NumWide   = 2,
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 64
);
  localparam int unsigned StrbWidth = DataWidth / 8;

  logic [NumNarrow-1:0]           narrow_req_i;
  logic [NumNarrow-1:0]           narrow_gnt_o;
  logic [NumNarrow*AddrWidth-1:0] narrow_addr_i;
  logic [NumNarrow-1:0]           narrow_we_i;
  logic [NumNarrow*DataWidth-1:0] narrow_wdata_i;
  logic [NumNarrow*StrbWidth-1:0] narrow_strb_i;
  logic [NumNarrow-1:0]           narrow_rvalid_o;
  logic [DataWidth-1:0]           narrow_rdata_o;

  logic [NumWide-1:0]             wide_req_i;
  logic [NumWide-1:0]             wide_gnt_o;
  logic [NumWide*AddrWidth-1:0]   wide_addr_i;
  logic [NumWide-1:0]             wide_we_i;
  logic [NumWide*DataWidth-1:0]   wide_wdata_i;
  logic [NumWide*StrbWidth-1:0]   wide_strb_i;
  logic [NumWide-1:0]             wide_rvalid_o;
  logic [DataWidth-1:0]           wide_rdata_o;

  logic                           bank_req_o;
  logic                           bank_we_o;
  logic [AddrWidth-1:0]           bank_addr_o;
  logic [DataWidth-1:0]           bank_wdata_o;
  logic [StrbWidth-1:0]           bank_strb_o;
  logic [DataWidth-1:0]           bank_rdata_i;

  modport slave (
    input  narrow_req_i, narrow_addr_i, narrow_we_i, narrow_wdata_i, narrow_strb_i,
    output narrow_gnt_o, narrow_rvalid_o, narrow_rdata_o,
    input  wide_req_i, wide_addr_i, wide_we_i, wide_wdata_i, wide_strb_i,
    output wide_gnt_o, wide_rvalid_o, wide_rdata_o,
    output bank_req_o, bank_we_o, bank_addr_o, bank_wdata_o, bank_strb_o,
    input  bank_rdata_i
  );

  modport master (
    output narrow_req_i, narrow_addr_i, narrow_we_i, narrow_wdata_i, narrow_strb_i,
    input  narrow_gnt_o, narrow_rvalid_o, narrow_rdata_o,
    output wide_req_i, wide_addr_i, wide_we_i, wide_wdata_i, wide_strb_i,
    input  wide_gnt_o, wide_rvalid_o, wide_rdata_o,
    input  bank_req_o, bank_we_o, bank_addr_o, bank_wdata_o, bank_strb_o,
    output bank_rdata_i
  );
endinterface

// File: rtl/memory_island_bank_arbiter.sv
// Arbitrates one memory-island SRAM bank between narrow (default priority) and wide requesters,
// with a starvation boost for the wide class and fixed-latency response routing.
module memory_island_bank_arbiter #(
  parameter int unsigned NumNarrow        = 2,
  parameter int unsigned NumWide          = 2,
  parameter int unsigned AddrWidth        = 10,
  parameter int unsigned DataWidth        = 64,
  parameter int unsigned WidePriorityWait = 1,
  parameter int unsigned BankLatency      = 1
) (
  input logic                         clk_i,
  input logic                         rst_ni,
  memory_island_bank_arbiter_if.slave bus
);
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned NPtrW     = (NumNarrow > 1) ? $clog2(NumNarrow) : 1;
  localparam int unsigned WPtrW     = (NumWide > 1) ? $clog2(NumWide) : 1;
  localparam int unsigned IdxW      = (NPtrW > WPtrW) ? NPtrW : WPtrW;
  localparam int unsigned CntW      = (WidePriorityWait > 0) ? $clog2(WidePriorityWait + 1) : 1;

  typedef enum logic {NARROW_PRIO, WIDE_BOOST} state_e;

  typedef struct packed {
    logic            valid;
    logic            wide;
    logic [IdxW-1:0] idx;
  } resp_t;

  state_e                      state_q, state_d;
  logic   [NPtrW-1:0]          nptr_q, nptr_d;
  logic   [WPtrW-1:0]          wptr_q, wptr_d;
  logic   [CntW-1:0]           cnt_q, cnt_d;
  resp_t  [BankLatency-1:0]    pipe_q;
  resp_t                       head, tail;

  logic                        n_any, w_any, w_stall;
  logic   [NPtrW-1:0]          n_sel;
  logic   [WPtrW-1:0]          w_sel;
  logic   [NumNarrow-1:0]      n_gnt;
  logic   [NumWide-1:0]        w_gnt;
  int unsigned                 nk, wk;

  // Round-robin search within each class, starting at that class's pointer.
  always_comb begin
    n_any = 1'b0;
    n_sel = '0;
    nk    = 0;
    for (int unsigned i = 0; i < NumNarrow; i++) begin
      nk = (32'(nptr_q) + i) % NumNarrow;
      if (!n_any && bus.narrow_req_i[NPtrW'(nk)]) begin
        n_any = 1'b1;
        n_sel = NPtrW'(nk);
      end
    end
    w_any = 1'b0;
    w_sel = '0;
    wk    = 0;
    for (int unsigned i = 0; i < NumWide; i++) begin
      wk = (32'(wptr_q) + i) % NumWide;
      if (!w_any && bus.wide_req_i[WPtrW'(wk)]) begin
        w_any = 1'b1;
        w_sel = WPtrW'(wk);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= NARROW_PRIO;
      nptr_q  <= '0;
      wptr_q  <= '0;
      cnt_q   <= '0;
      pipe_q  <= '0;
    end else begin
      state_q   <= state_d;
      nptr_q    <= nptr_d;
      wptr_q    <= wptr_d;
      cnt_q     <= cnt_d;
      pipe_q[0] <= head;
      for (int unsigned i = 1; i < BankLatency; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // The counter holds at WidePriorityWait-1 while the boost is pending, so it never exceeds it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nptr_d  = nptr_q;
    wptr_d  = wptr_q;
    w_stall = w_any && !(|w_gnt);
    if (|w_gnt) begin
      cnt_d   = '0;
      state_d = NARROW_PRIO;
    end else if (w_stall) begin
      if ((WidePriorityWait > 0) && (cnt_q == CntW'(WidePriorityWait - 1))) begin
        state_d = WIDE_BOOST;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      state_d = NARROW_PRIO;
    end
    if (|n_gnt) nptr_d = (n_sel == NPtrW'(NumNarrow - 1)) ? '0 : n_sel + 1'b1;
    if (|w_gnt) wptr_d = (w_sel == WPtrW'(NumWide - 1)) ? '0 : w_sel + 1'b1;
  end

  always_comb begin
    n_gnt = '0;
    w_gnt = '0;
    if ((state_q == WIDE_BOOST) && w_any) w_gnt[w_sel] = 1'b1;
    else if (n_any)                       n_gnt[n_sel] = 1'b1;
    else if (w_any)                       w_gnt[w_sel] = 1'b1;
  end

  always_comb begin
    bus.narrow_gnt_o = n_gnt;
    bus.wide_gnt_o   = w_gnt;
    bus.bank_req_o   = (|n_gnt) | (|w_gnt);
    bus.bank_we_o    = 1'b0;
    bus.bank_addr_o  = '0;
    bus.bank_wdata_o = '0;
    bus.bank_strb_o  = '0;
    for (int unsigned i = 0; i < NumNarrow; i++) begin
      if (n_gnt[i]) begin
        bus.bank_we_o    = bus.narrow_we_i[i];
        bus.bank_addr_o  = bus.narrow_addr_i[i*AddrWidth +: AddrWidth];
        bus.bank_wdata_o = bus.narrow_wdata_i[i*DataWidth +: DataWidth];
        bus.bank_strb_o  = bus.narrow_strb_i[i*StrbWidth +: StrbWidth];
      end
    end
    for (int unsigned i = 0; i < NumWide; i++) begin
      if (w_gnt[i]) begin
        bus.bank_we_o    = bus.wide_we_i[i];
        bus.bank_addr_o  = bus.wide_addr_i[i*AddrWidth +: AddrWidth];
        bus.bank_wdata_o = bus.wide_wdata_i[i*DataWidth +: DataWidth];
        bus.bank_strb_o  = bus.wide_strb_i[i*StrbWidth +: StrbWidth];
      end
    end
  end

  always_comb begin
    head.valid = (|n_gnt) | (|w_gnt);
    head.wide  = |w_gnt;
    head.idx   = (|w_gnt) ? IdxW'(w_sel) : IdxW'(n_sel);
    tail       = pipe_q[BankLatency-1];
    for (int unsigned i = 0; i < NumNarrow; i++)
      bus.narrow_rvalid_o[i] = tail.valid && !tail.wide && (tail.idx == IdxW'(i));
    for (int unsigned i = 0; i < NumWide; i++)
      bus.wide_rvalid_o[i] = tail.valid && tail.wide && (tail.idx == IdxW'(i));
    bus.narrow_rdata_o = bus.bank_rdata_i;
    bus.wide_rdata_o   = bus.bank_rdata_i;
  end
endmodule
